// File: rtl/pollard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pollard_pkg
//  Purpose  : Shared constants and types for the Pollard p-1 datapath.
//  Revision : 1.0  initial release
// ============================================================================
package pollard_pkg;

  // Base width of the exponent stage; the prime source emits values this wide.
  localparam int PRIME_W = 9;

  // Sweep controller states of the prime source.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    TEST = 3'd1,
    DIV  = 3'd2,
    EMIT = 3'd3,
    DONE = 3'd4
  } prime_state_t;

endpackage
`default_nettype wire

// File: rtl/prime_source_trial_rem.sv
`default_nettype none
// ============================================================================
//  Module   : trial_rem
//  Purpose  : Remainder of c modulo d by repeated subtraction, one step per
//             clock. load restarts the loop with r = c; rem_valid flags r < d.
//  Revision : 1.0  initial release
// ============================================================================
module trial_rem #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  output logic [W-1:0] r,
  output logic         rem_valid
);

  logic [W-1:0] r_q, r_d;
  logic         active_q, active_d;

  // Next remainder: reload on load, otherwise subtract while r still >= d.
  always_comb begin
    r_d      = r_q;
    active_d = active_q;
    if (load) begin
      r_d      = c;
      active_d = 1'b1;
    end else if (active_q && (r_q >= d)) begin
      r_d = r_q - d;
    end
  end

  // Remainder and activity registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q      <= '0;
      active_q <= 1'b0;
    end else begin
      r_q      <= r_d;
      active_q <= active_d;
    end
  end

  assign r         = r_q;
  // The divisor input is only meaningful while active, so gate on it.
  assign rem_valid = active_q && (r_q < d);

endmodule
`default_nettype wire

// File: rtl/prime_source.sv
`default_nettype none
// ============================================================================
//  Module   : prime_source
//  Purpose  : Emits every prime 2..limit in ascending order over a
//             valid/ready handshake, using trial division by subtraction.
//  Revision : 1.0  initial release
// ============================================================================
module prime_source
  import pollard_pkg::*;
#(
  parameter int PW = PRIME_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [PW-1:0] limit,
  output logic [PW-1:0] prime,
  output logic          prime_valid,
  input  logic          prime_ready,
  output logic          busy,
  output logic          done
);

  // Candidate/divisor are one bit wider so c can step past 2^PW-1 safely.
  localparam int CW = PW + 1;
  localparam int SW = 2 * CW;

  localparam logic [2:0] ST_IDLE = IDLE;
  localparam logic [2:0] ST_TEST = TEST;
  localparam logic [2:0] ST_DIV  = DIV;
  localparam logic [2:0] ST_EMIT = EMIT;
  localparam logic [2:0] ST_DONE = DONE;

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] lim_q, lim_d;
  logic [CW-1:0] c_q, c_d;
  logic [CW-1:0] d_q, d_d;
  logic [SW-1:0] dsq_q, dsq_d;   // tracks d*d incrementally
  logic [PW-1:0] prime_q, prime_d;
  logic          done_q, done_d;

  logic          w_load;
  logic [CW-1:0] w_r;
  logic          w_rem_valid;
  logic          w_do_next;
  logic [CW-1:0] w_c_inc;
  logic [SW-1:0] w_dsq_inc;
  logic [SW-1:0] w_c_wide;

  assign w_c_inc   = c_q + 1'b1;
  assign w_c_wide  = SW'(c_q);
  // (d+1)^2 = d^2 + 2d + 1, so no multiplier is needed.
  assign w_dsq_inc = dsq_q + SW'({d_q, 1'b0}) + SW'(1);

  trial_rem #(
    .W (CW)
  ) u_trial_rem (
    .clk       (clk),
    .rst       (rst),
    .load      (w_load),
    .c         (c_q),
    .d         (d_q),
    .r         (w_r),
    .rem_valid (w_rem_valid)
  );

  // Sweep sequencing: divisor stepping, emission and candidate advance.
  always_comb begin
    state_d   = state_q;
    lim_d     = lim_q;
    c_d       = c_q;
    d_d       = d_q;
    dsq_d     = dsq_q;
    prime_d   = prime_q;
    done_d    = done_q;
    w_load    = 1'b0;
    w_do_next = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          lim_d  = limit;
          c_d    = CW'(2);
          done_d = 1'b0;
          if (limit < PW'(2)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_TEST;
          end
        end
      end

      ST_TEST: begin
        d_d    = CW'(2);
        dsq_d  = SW'(4);
        w_load = 1'b1;
        if (SW'(4) > w_c_wide) begin
          state_d = ST_EMIT;
          prime_d = c_q[PW-1:0];
        end else begin
          state_d = ST_DIV;
        end
      end

      ST_DIV: begin
        if (w_rem_valid) begin
          if (w_r == '0) begin
            w_do_next = 1'b1;
          end else begin
            d_d    = d_q + 1'b1;
            dsq_d  = w_dsq_inc;
            w_load = 1'b1;
            if (w_dsq_inc > w_c_wide) begin
              state_d = ST_EMIT;
              prime_d = c_q[PW-1:0];
            end
          end
        end
      end

      ST_EMIT: begin
        if (prime_ready) begin
          w_do_next = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Advance to the next candidate or finish the sweep.
    if (w_do_next) begin
      c_d = w_c_inc;
      if (w_c_inc > {1'b0, lim_q}) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end else begin
        state_d = ST_TEST;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lim_q   <= '0;
      c_q     <= '0;
      d_q     <= '0;
      dsq_q   <= '0;
      prime_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lim_q   <= lim_d;
      c_q     <= c_d;
      d_q     <= d_d;
      dsq_q   <= dsq_d;
      prime_q <= prime_d;
      done_q  <= done_d;
    end
  end

  assign prime       = prime_q;
  assign prime_valid = (state_q == ST_EMIT);
  assign busy        = (state_q == ST_TEST) || (state_q == ST_DIV) ||
                       (state_q == ST_EMIT);
  assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_prime_source.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prime_source
//  Purpose  : Self-checking bench for prime_source.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prime_source;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [8:0] limit;
  logic [8:0] prime;
  logic       prime_valid;
  logic       prime_ready;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int lim;
    bit rnd;
    int exp_cnt;
    int exp_last;
    int inject;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  prime_source dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .limit       (limit),
    .prime       (prime),
    .prime_valid (prime_valid),
    .prime_ready (prime_ready),
    .busy        (busy),
    .done        (done)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit is_prime(input int n);
    if (n < 2) return 1'b0;
    for (int k = 2; k * k <= n; k++)
      if (n % k == 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_sweep(input int lim, input bit rnd, input int exp_cnt,
                           input int exp_last, input int inject, input int budget);
    int  got[$];
    int  model[$];
    int  held;
    bit  holding;
    bit  finished;
    int  cyc;
    int  extra;
    int  n;
    for (int v = 2; v <= lim; v++)
      if (is_prime(v)) model.push_back(v);

    @(negedge clk);
    limit = 9'(lim);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (lim >= 2) chk($sformatf("done_clears_lim%0d", lim), int'(done), 0);

    holding  = 1'b0;
    finished = 1'b0;
    held     = 0;
    for (cyc = 0; cyc < budget; cyc++) begin
      start = (cyc == inject);
      if (cyc == inject) begin
        limit = 9'd5;
        chk("busy_at_inject", int'(busy), 1);
      end
      prime_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (holding) begin
        chk("hold_valid", int'(prime_valid), 1);
        chk("hold_prime", int'(prime), held);
      end
      if (prime_valid && prime_ready) got.push_back(int'(prime));
      holding = prime_valid && !prime_ready;
      held    = int'(prime);
      if (done && !prime_valid) begin
        finished = 1'b1;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk($sformatf("finished_lim%0d", lim), int'(finished), 1);
    if (lim < 2) chk($sformatf("quick_done_lim%0d", lim), int'(cyc <= 1), 1);

    prime_ready = 1'b1;
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (prime_valid) extra++;
    end
    chk("no_extra_valid", extra, 0);
    chk("busy_after", int'(busy), 0);
    chk("done_after", int'(done), 1);

    chk($sformatf("count_model_lim%0d", lim), got.size(), model.size());
    if (exp_cnt >= 0) chk($sformatf("count_table_lim%0d", lim), got.size(), exp_cnt);
    if (exp_last > 0 && got.size() > 0) chk($sformatf("last_lim%0d", lim), got[$], exp_last);
    n = (got.size() < model.size()) ? got.size() : model.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("seq_lim%0d_idx%0d", lim, i), got[i], model[i]);
  endtask

  initial begin
    int  lim;
    bit  found;
    vecs[0] = '{lim: 20,  rnd: 1'b0, exp_cnt: 8,  exp_last: 19,  inject: -1};
    vecs[1] = '{lim: 2,   rnd: 1'b0, exp_cnt: 1,  exp_last: 2,   inject: -1};
    vecs[2] = '{lim: 1,   rnd: 1'b0, exp_cnt: 0,  exp_last: 0,   inject: -1};
    vecs[3] = '{lim: 0,   rnd: 1'b0, exp_cnt: 0,  exp_last: 0,   inject: -1};
    vecs[4] = '{lim: 30,  rnd: 1'b1, exp_cnt: 10, exp_last: 29,  inject: -1};
    vecs[5] = '{lim: 20,  rnd: 1'b0, exp_cnt: 8,  exp_last: 19,  inject: 15};
    vecs[6] = '{lim: 12,  rnd: 1'b0, exp_cnt: 5,  exp_last: 11,  inject: -1};
    vecs[7] = '{lim: 511, rnd: 1'b0, exp_cnt: 97, exp_last: 509, inject: -1};

    rst         = 1'b1;
    start       = 1'b0;
    limit       = '0;
    prime_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_prime", int'(prime), 0);
    chk("reset_valid", int'(prime_valid), 0);
    chk("reset_busy",  int'(busy), 0);
    chk("reset_done",  int'(done), 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      run_sweep(vecs[i].lim, vecs[i].rnd, vecs[i].exp_cnt, vecs[i].exp_last,
                vecs[i].inject, (vecs[i].lim > 100) ? 400000 : 20000);

    // Reset while a prime (7) is being held un-accepted.
    @(negedge clk);
    limit       = 9'd10;
    start       = 1'b1;
    prime_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      if (prime_valid && prime == 9'd7) begin
        prime_ready = 1'b0;
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("found_7", int'(found), 1);
    @(negedge clk);
    chk("held_7_valid", int'(prime_valid), 1);
    chk("held_7_prime", int'(prime), 7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_prime", int'(prime), 0);
    chk("rst_mid_valid", int'(prime_valid), 0);
    chk("rst_mid_busy",  int'(busy), 0);
    chk("rst_mid_done",  int'(done), 0);
    run_sweep(10, 1'b0, 4, 7, -1, 20000);

    // Randomised limits with randomised back-pressure.
    for (int t = 0; t < 3; t++) begin
      lim = int'($urandom_range(3, 80));
      run_sweep(lim, 1'b1, -1, 0, -1, 40000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prime_source.md
Name: prime_source

Overview:
Sequential prime generator for the Pollard p-1 datapath. After a start pulse it emits every prime p with 2 <= p <= limit, in ascending order, one per valid/ready transfer. It sits directly upstream of the exponent-finding stage: prime drives that stage's 9-bit base input, and each accepted prime triggers one exponent computation against the smoothness bound. Primality is decided by trial division, with the remainder computed by repeated subtraction, so no divider or multiplier is inferred.

Parameters:
PW, 9, prime/limit width; matches the base width of the exponent stage.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous active-high reset.
start  input  1  one-cycle pulse; launches a sweep, sampled only in IDLE or DONE.
limit  input  PW  inclusive upper bound; captured on the accepted start.
prime  output  PW  current prime; stable while prime_valid=1.
prime_valid  output  1  prime holds an unconsumed prime.
prime_ready  input  1  consumer accepts; transfer on prime_valid & prime_ready at the clk edge.
busy  output  1  sweep in progress (TEST, DIV or EMIT).
done  output  1  sweep finished; a level that clears on the next accepted start or on rst.

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE; prime=0, prime_valid=0, busy=0, done=0; internal candidate, divisor and remainder cleared. Reset wins over every other input in the same cycle, including mid-sweep or mid-transfer. An un-accepted prime is discarded.
- Internal widths: candidate c and divisor d are PW+1 bits, so c can reach 2^PW without wrapping. Remainder r is PW+1 bits. d*d is computed at 2*(PW+1) bits.
- States: IDLE, TEST, DIV, EMIT, DONE.
- IDLE/DONE + start: latch limit into lim_q, set c=2, clear done, assert busy.
  - If lim_q < 2: go directly to DONE with done=1 and no prime emitted.
  - Otherwise go to TEST.
  - start in other states is ignored.
- TEST: set d=2, r=c.
  - If d*d > c: prime found, go to EMIT.
  - Otherwise go to DIV.
- DIV: one subtraction per cycle; if r >= d then r <= r-d. When r < d:
  - r==0: c is composite; go to NEXT.
  - r!=0: d <= d+1, r <= c. If (d+1)*(d+1) > c, go to EMIT; otherwise stay in DIV.
- NEXT (a transient action inside DIV/EMIT, not a separate state): c <= c+1. If c+1 > lim_q: go to DONE (busy=0, done=1). Otherwise go to TEST.
- EMIT: prime=c[PW-1:0], prime_valid=1. Hold prime and prime_valid until prime_ready=1. On the transfer edge, drop prime_valid and perform NEXT. prime_valid is never raised outside EMIT.
- Latency is data-dependent: bounded by roughly c*sqrt(c)/2 cycles per candidate. Only ordering and handshake are contractual, not cycle counts.
- Back-to-back: prime_valid may re-assert no earlier than 2 cycles after a transfer.
- limit=2^PW-1 (511): the last prime is 509. c advances to 512 > lim_q, which ends the sweep without overflow.
- prime_ready while prime_valid=0 has no effect.

Decomposition:
- Package pollard_pkg:
  - constant PRIME_W=9 (shared with the exponent stage's base width).
  - state enum prime_state_t {IDLE, TEST, DIV, EMIT, DONE}.
- Sub-module trial_rem: inputs clk, rst, load, c, d; outputs r, rem_valid. It performs the subtraction loop, and prime_source sequences divisors around it.

Test Plan:
- limit=20, prime_ready tied 1, start pulse -> transfers 2,3,5,7,11,13,17,19 in order, then done=1, busy=0, with no extra prime_valid.
- limit=2 -> exactly one transfer (2), then done. limit=1 and limit=0 -> done=1 within 2 cycles of start, prime_valid never asserted.
- limit=30 with prime_ready toggling pseudo-randomly -> prime stable while valid&!ready, and no prime dropped or duplicated: sequence 2..29 (10 primes).
- limit=511, ready=1 -> 97 transfers, the last being 509, then done. No X and no wrap to small values.
- rst asserted while prime_valid=1 (holding 7, ready=0) -> next cycle all outputs 0, state IDLE. A subsequent start with limit=10 yields 2,3,5,7.
- start pulsed while busy -> ignored, sequence unchanged. start pulsed in DONE with a new limit=12 -> done clears, and the sweep 2,3,5,7,11 is emitted.
